// File: rtl/nes_joypad_port_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nes_joypad_port_if                                                        |
// | CPU-side bus for the $4016/$4017 controller ports.                        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface nes_joypad_port_if;
   logic [2:0] addr4016w;
   logic       naddr4016r;
   logic       naddr4017r;
   logic [7:0] rdata;
   logic       rdata_oe;

   modport master (
      output addr4016w,
      output naddr4016r,
      output naddr4017r,
      input  rdata,
      input  rdata_oe
   );

   modport slave (
      input  addr4016w,
      input  naddr4016r,
      input  naddr4017r,
      output rdata,
      output rdata_oe
   );
endinterface
`default_nettype wire

// File: rtl/nes_joypad_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nes_joypad_port                                                           |
// | Two CD4021-style serial controller ports behind $4016/$4017.              |
// | Optional four-player adapter: define NES_JOYPAD_FOUR_SCORE_EN.            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module nes_joypad_port #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] OPEN_BUS_HI = 8'h40
) (
   input  wire logic       clock,
   input  wire logic       reset,
   nes_joypad_port_if.slave bus,
   input  wire logic [7:0] buttons_p1,
   input  wire logic [7:0] buttons_p2
`ifdef NES_JOYPAD_FOUR_SCORE_EN
   ,
   input  wire logic [7:0] buttons_p3,
   input  wire logic [7:0] buttons_p4
`endif
);

`ifdef NES_JOYPAD_FOUR_SCORE_EN
   localparam int NUM_PADS = 4;
   localparam int SR_W     = 24;
`else
   localparam int NUM_PADS = 2;
   localparam int SR_W     = 8;
`endif

   logic [7:0]      pad_raw   [NUM_PADS];
   logic [7:0]      btn_s     [NUM_PADS];
   logic [SR_W-1:0] load_val  [2];
   logic [1:0]      nread;
   logic [1:0]      serial_bit;
   logic            strobe;
   logic [7:0]      rdata_q;
   logic            rdata_oe_q;
   logic            unused_addr_bits;

   assign pad_raw[0] = buttons_p1;
   assign pad_raw[1] = buttons_p2;
`ifdef NES_JOYPAD_FOUR_SCORE_EN
   assign pad_raw[2] = buttons_p3;
   assign pad_raw[3] = buttons_p4;
`endif

   assign strobe           = bus.addr4016w[0];
   assign unused_addr_bits = ^bus.addr4016w[2:1];
   assign nread            = {bus.naddr4017r, bus.naddr4016r};

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_sync
      logic [7:0] stage [SYNC_STAGES];

      always_ff @(posedge clock) begin
         if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
               stage[s] <= '0;
            end
         end else begin
            stage[0] <= pad_raw[p];
            for (int s = 1; s < SYNC_STAGES; s++) begin
               stage[s] <= stage[s-1];
            end
         end
      end

      assign btn_s[p] = stage[SYNC_STAGES-1];
   end

   // Four-score serial frame, LSB first: pad A, pad B, then the adapter signature.
`ifdef NES_JOYPAD_FOUR_SCORE_EN
   assign load_val[0] = {8'h08, btn_s[2], btn_s[0]};
   assign load_val[1] = {8'h04, btn_s[3], btn_s[1]};
`else
   assign load_val[0] = btn_s[0];
   assign load_val[1] = btn_s[1];
`endif

   for (genvar q = 0; q < 2; q++) begin : g_port
      logic [SR_W-1:0] sr;
      logic            hist;
      logic            rise;

      // Shift at the end of the read so the CPU sees a stable bit for the whole access.
      assign rise = ~hist & nread[q];

      always_ff @(posedge clock) begin
         if (reset) begin
            sr   <= '0;
            hist <= 1'b1;
         end else begin
            hist <= nread[q];
            if (strobe) begin
               sr <= load_val[q];
            end else if (rise) begin
               sr <= {1'b1, sr[SR_W-1:1]};
            end
         end
      end

`ifdef NES_JOYPAD_FOUR_SCORE_EN
      logic [4:0] cnt;

      always_ff @(posedge clock) begin
         if (reset) begin
            cnt <= '0;
         end else if (strobe) begin
            cnt <= '0;
         end else if (rise && (cnt != 5'd24)) begin
            cnt <= cnt + 5'd1;
         end
      end

      assign serial_bit[q] = (cnt >= 5'd24) ? 1'b1 : sr[0];
`else
      assign serial_bit[q] = sr[0];
`endif
   end

   // Port 1 wins if software ever drives both strobes at once.
   always_comb begin
      rdata_q    = '0;
      rdata_oe_q = 1'b0;
      if (!reset) begin
         if (!nread[0]) begin
            rdata_q    = {OPEN_BUS_HI[7:1], serial_bit[0]};
            rdata_oe_q = 1'b1;
         end else if (!nread[1]) begin
            rdata_q    = {OPEN_BUS_HI[7:1], serial_bit[1]};
            rdata_oe_q = 1'b1;
         end
      end
   end

   assign bus.rdata    = rdata_q;
   assign bus.rdata_oe = rdata_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_joypad_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nes_joypad_port                                                        |
// | Table-driven directed bench for nes_joypad_port.                          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_nes_joypad_port;

   localparam logic [7:0] OB = 8'h40;

   typedef struct {
      logic       rst;
      logic       stb;
      logic       n16;
      logic       n17;
      logic [7:0] p1;
      logic [7:0] p2;
      logic [7:0] p3;
      logic [7:0] p4;
      logic [7:0] exp_rd;
      logic       exp_oe;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] p1, p2, p3, p4;
   logic [7:0] cur_p1, cur_p2, cur_p3, cur_p4;
   int         checks;
   int         errors;
   vec_t       vq[$];

   nes_joypad_port_if bus ();

   nes_joypad_port #(
      .SYNC_STAGES(2),
      .OPEN_BUS_HI(8'h40)
   ) dut (
      .clock      (clk),
      .reset      (rst),
      .bus        (bus.slave),
      .buttons_p1 (p1),
      .buttons_p2 (p2)
`ifdef NES_JOYPAD_FOUR_SCORE_EN
      ,
      .buttons_p3 (p3),
      .buttons_p4 (p4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic s, input logic a, input logic b,
                               input logic [7:0] erd, input logic eoe);
      vec_t v;
      v.rst = r; v.stb = s; v.n16 = a; v.n17 = b;
      v.p1 = cur_p1; v.p2 = cur_p2; v.p3 = cur_p3; v.p4 = cur_p4;
      v.exp_rd = erd; v.exp_oe = eoe;
      vq.push_back(v);
   endfunction

   function automatic void idle();
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
   endfunction

   function automatic void load();
      for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
   endfunction

   function automatic void rd1(input logic b);
      add(1'b0, 1'b0, 1'b0, 1'b1, {OB[7:1], b}, 1'b1);
      idle();
   endfunction

   function automatic void rd2(input logic b);
      add(1'b0, 1'b0, 1'b1, 1'b0, {OB[7:1], b}, 1'b1);
      idle();
   endfunction

   task automatic check(input string name, input int row, input logic [7:0] rd, input logic oe,
                        input logic [7:0] erd, input logic eoe);
      checks++;
      if (rd !== erd || oe !== eoe) begin
         errors++;
         $display("FAIL %s row %0d: rdata=%h oe=%b, expected rdata=%h oe=%b",
                  name, row, rd, oe, erd, eoe);
      end
   endtask

   initial begin
      logic [7:0] p1hist [43];
      logic       bit_e;

      checks = 0; errors = 0;
      cur_p1 = 8'hA5; cur_p2 = 8'h00; cur_p3 = 8'h00; cur_p4 = 8'h00;

      // Reset: A5 on the pins, strobe low, one read right after release.
      rd1(1'b0);

      // A + Start: serial 1,0,0,1,0,0,0,0 then exhaustion.
      cur_p1 = 8'h09;
      load();
      for (int i = 0; i < 8; i++) rd1(cur_p1[i]);
`ifdef NES_JOYPAD_FOUR_SCORE_EN
      for (int i = 0; i < 4; i++) rd1(1'b0);
`else
      for (int i = 0; i < 4; i++) rd1(1'b1);
`endif

      // Long read: five low cycles, one shift.
      cur_p1 = 8'h01;
      load();
      for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1);
      idle();
      rd1(1'b0);

      // Strobe held high, A toggling every 10 cycles; seen 3 rows later (2 sync + load).
      for (int r = 0; r < 43; r++) begin
         p1hist[r] = (r < 3) ? 8'h01 : {7'b0, (((r - 3) / 10) % 2) == 1};
         cur_p1 = p1hist[r];
         if (r < 3 || (r % 2) == 1) begin
            add(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
         end else begin
            bit_e = p1hist[r-3][0];
            add(1'b0, 1'b1, 1'b0, 1'b1, {OB[7:1], bit_e}, 1'b1);
         end
      end

      // Independent ports, both-low priority, port 2 exhaustion.
      cur_p1 = 8'hFF; cur_p2 = 8'h00;
      load();
      for (int i = 0; i < 4; i++) begin
         rd1(1'b1);
         rd2(1'b0);
      end
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 1'b1);
      idle();
`ifdef NES_JOYPAD_FOUR_SCORE_EN
      for (int i = 0; i < 5; i++) rd2(1'b0);
`else
      rd2(1'b0); rd2(1'b0); rd2(1'b0); rd2(1'b1); rd2(1'b1);
`endif
      rd1(1'b1);

      // Rising read edge coinciding with strobe: reload, not shift.
      cur_p1 = 8'h02;
      load();
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
      idle();
      rd1(1'b0);
      rd1(1'b1);

      // Reset in the middle of a read.
      cur_p1 = 8'h01;
      load();
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
      idle();
      rd1(1'b0);

`ifdef NES_JOYPAD_FOUR_SCORE_EN
      cur_p1 = 8'h01; cur_p3 = 8'h80;
      load();
      for (int i = 0; i < 24; i++) rd1(i == 0 || i == 15 || i == 19);
      rd1(1'b1);
      rd1(1'b1);
`else
      cur_p1 = 8'h00;
      load();
      for (int i = 0; i < 8; i++) rd1(1'b0);
      rd1(1'b1);
      rd1(1'b1);
`endif

      // Hand-driven reset with a read strobe asserted.
      rst = 1'b1;
      bus.addr4016w = 3'b000; bus.naddr4016r = 1'b1; bus.naddr4017r = 1'b1;
      p1 = 8'hA5; p2 = 8'h00; p3 = 8'h00; p4 = 8'h00;
      repeat (2) @(posedge clk);
      #1 bus.naddr4016r = 1'b0;
      @(negedge clk);
      check("reset_gate", -1, bus.rdata, bus.rdata_oe, 8'h00, 1'b0);
      @(posedge clk);
      #1 bus.naddr4016r = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk);
         #1;
         rst             = vq[i].rst;
         bus.addr4016w   = {2'b00, vq[i].stb};
         bus.naddr4016r  = vq[i].n16;
         bus.naddr4017r  = vq[i].n17;
         p1 = vq[i].p1; p2 = vq[i].p2; p3 = vq[i].p3; p4 = vq[i].p4;
         @(negedge clk);
         check("vector", i, bus.rdata, bus.rdata_oe, vq[i].exp_rd, vq[i].exp_oe);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
